// File: rtl/pe_bfly_pkg.sv
// Shared poly-arith definitions: coefficient type, default modulus and butterfly modes.
package pe_bfly_pkg;

  localparam int PB_COEFF_W = 12;
  localparam int PB_Q       = 3329;

  typedef logic [PB_COEFF_W-1:0] coeff_t;

  typedef enum logic [1:0] {
    MODE_CT     = 2'd0,
    MODE_GS     = 2'd1,
    MODE_MAC    = 2'd2,
    MODE_ADDSUB = 2'd3
  } mode_e;

endpackage

// File: rtl/pe_bfly_arith.sv
// Modular arithmetic leaves: add, subtract, pipelined multiply and divide-by-2 (mod Q).
// mod_div2 only exists when PE_BFLY_HALVE_EN is defined.
module mod_add #(
  parameter int W = 12,
  parameter int Q = 3329
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);
  localparam logic [W:0] QW = (W+1)'(Q);
  logic [W:0] s_w;

  assign s_w = {1'b0, a} + {1'b0, b};
  assign s   = (s_w >= QW) ? W'(s_w - QW) : W'(s_w);
endmodule

module mod_sub #(
  parameter int W = 12,
  parameter int Q = 3329
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] d
);
  localparam logic [W:0] QW = (W+1)'(Q);

  // Borrow wraps by adding Q back.
  assign d = (a >= b) ? (a - b) : W'({1'b0, a} + QW - {1'b0, b});
endmodule

module mod_mul #(
  parameter int W   = 12,
  parameter int Q   = 3329,
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic [LAT-1:0] en,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   r
);
  localparam logic [2*W-1:0] QP = (2*W)'(Q);
  logic [2*W-1:0] prod_q [LAT];

  always_ff @(posedge clk) begin
    if (en[0]) prod_q[0] <= (2*W)'(a) * (2*W)'(b);
    for (int i = 1; i < LAT; i++) begin
      if (en[i]) prod_q[i] <= prod_q[i-1];
    end
  end

  // Reduction by a constant modulus sits after the last register for retiming.
  assign r = W'(prod_q[LAT-1] % QP);
endmodule

`ifdef PE_BFLY_HALVE_EN
module mod_div2 #(
  parameter int W = 12,
  parameter int Q = 3329
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  localparam logic [W:0] QW = (W+1)'(Q);
  logic [W:0] t;

  assign t = {1'b0, x} + (x[0] ? QW : '0);
  assign y = W'(t >> 1);
endmodule
`endif

// File: rtl/pe_bfly_delay.sv
// Register line of parametrised depth; each stage loads from its predecessor when enabled.
module pe_bfly_delay #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic [DEPTH-1:0] en,
  input  logic [W-1:0]     d,
  output logic [W-1:0]     q
);
  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en[0]) stage_q[0] <= d;
    for (int i = 1; i < DEPTH; i++) begin
      if (en[i]) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[DEPTH-1];
endmodule

// File: rtl/pe_bfly.sv
// NTT/INTT butterfly PE (CT, GS, MAC, ADDSUB) with MUL_LAT+1 fixed latency and collapsing bubbles.
// PE_BFLY_HALVE_EN: halve GS outputs mod Q after the final register.
module pe_bfly
  import pe_bfly_pkg::*;
#(
  parameter int COEFF_W = PB_COEFF_W,
  parameter int Q       = PB_Q,
  parameter int MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COEFF_W-1:0] a_i,
  input  logic [COEFF_W-1:0] b_i,
  input  logic [COEFF_W-1:0] w_i,
  input  logic [1:0]         mode_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [COEFF_W-1:0] u_o,
  output logic [COEFF_W-1:0] v_o,
  output logic               valid_o,
  input  logic               ready_i
);
  localparam int N  = MUL_LAT + 1;
  localparam int DW = 2 + 3 * COEFF_W;

  logic [N-1:0]       vld_q;
  logic [N-1:0]       en;
  logic               accept;
  logic [COEFF_W-1:0] sum_in, dif_in, mul_x, mul_t;
  logic [COEFF_W-1:0] a_d, s_d, d_d, sum_out, dif_out;
  logic [COEFF_W-1:0] u_nxt, v_nxt, u_q, v_q;
  logic [DW-1:0]      dly_d, dly_q;
  mode_e              mode_d;

  assign valid_o = vld_q[N-1];
  assign ready_o = ready_i || !vld_q[N-1];
  assign accept  = valid_i && ready_o;

  // A stage holds only when it and every later stage are full and the sink is stalled.
  for (genvar i = 0; i < N; i++) begin : g_en
    assign en[i] = ready_i || !(&vld_q[N-1:i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      if (en[0]) vld_q[0] <= accept;
      for (int i = 1; i < N; i++) begin
        if (en[i]) vld_q[i] <= vld_q[i-1];
      end
    end
  end

  mod_add #(.W(COEFF_W), .Q(Q)) u_add_in (.a(a_i), .b(b_i), .s(sum_in));
  mod_sub #(.W(COEFF_W), .Q(Q)) u_sub_in (.a(a_i), .b(b_i), .d(dif_in));

  assign mul_x = (mode_i == MODE_GS) ? dif_in : b_i;

  mod_mul #(.W(COEFF_W), .Q(Q), .LAT(MUL_LAT)) u_mul (
    .clk (clk),
    .en  (en[MUL_LAT-1:0]),
    .a   (mul_x),
    .b   (w_i),
    .r   (mul_t)
  );

  assign dly_d = {mode_i, a_i, sum_in, dif_in};

  pe_bfly_delay #(.W(DW), .DEPTH(MUL_LAT)) u_dly (
    .clk (clk),
    .en  (en[MUL_LAT-1:0]),
    .d   (dly_d),
    .q   (dly_q)
  );

  assign mode_d = mode_e'(dly_q[DW-1 -: 2]);
  assign a_d    = dly_q[3*COEFF_W-1 -: COEFF_W];
  assign s_d    = dly_q[2*COEFF_W-1 -: COEFF_W];
  assign d_d    = dly_q[COEFF_W-1:0];

  mod_add #(.W(COEFF_W), .Q(Q)) u_add_out (.a(a_d), .b(mul_t), .s(sum_out));
  mod_sub #(.W(COEFF_W), .Q(Q)) u_sub_out (.a(a_d), .b(mul_t), .d(dif_out));

  always_comb begin
    u_nxt = sum_out;
    v_nxt = dif_out;
    case (mode_d)
      MODE_CT:     begin u_nxt = sum_out; v_nxt = dif_out; end
      MODE_GS:     begin u_nxt = s_d;     v_nxt = mul_t;   end
      MODE_MAC:    begin u_nxt = sum_out; v_nxt = mul_t;   end
      MODE_ADDSUB: begin u_nxt = s_d;     v_nxt = d_d;     end
      default:     begin u_nxt = sum_out; v_nxt = dif_out; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      u_q <= '0;
      v_q <= '0;
    end else if (en[N-1] && vld_q[N-2]) begin
      u_q <= u_nxt;
      v_q <= v_nxt;
    end
  end

`ifdef PE_BFLY_HALVE_EN
  mode_e              mode_q;
  logic [COEFF_W-1:0] u_half, v_half;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_CT;
    end else if (en[N-1] && vld_q[N-2]) begin
      mode_q <= mode_d;
    end
  end

  mod_div2 #(.W(COEFF_W), .Q(Q)) u_div_u (.x(u_q), .y(u_half));
  mod_div2 #(.W(COEFF_W), .Q(Q)) u_div_v (.x(v_q), .y(v_half));

  assign u_o = (mode_q == MODE_GS) ? u_half : u_q;
  assign v_o = (mode_q == MODE_GS) ? v_half : v_q;
`else
  assign u_o = u_q;
  assign v_o = v_q;
`endif

endmodule

// File: tb/tb_pe_bfly.sv
// Scoreboard bench for pe_bfly (Q=3329, MUL_LAT=2): directed vectors, stall, reset flush.
module tb_pe_bfly;
  localparam int QM  = 3329;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] a_i = '0, b_i = '0, w_i = '0;
  logic [1:0]  mode_i = '0;
  logic        valid_i = 1'b0, ready_i = 1'b1;
  logic        ready_o, valid_o;
  logic [11:0] u_o, v_o;

  pe_bfly #(.COEFF_W(12), .Q(QM), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .a_i(a_i), .b_i(b_i), .w_i(w_i), .mode_i(mode_i),
    .valid_i(valid_i), .ready_o(ready_o), .u_o(u_o), .v_o(v_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] u;
    logic [11:0] v;
    int          acc;
    bit          chk;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int halve(input int x);
`ifdef PE_BFLY_HALVE_EN
    return (x % 2 == 0) ? x / 2 : (x + QM) / 2;
`else
    return x;
`endif
  endfunction

  // Plain integer reference of the four butterfly modes.
  task automatic ref_model(input int a, input int b, input int w, input int m,
                           output int u, output int v);
    int t;
    t = (b * w) % QM;
    case (m)
      0: begin u = (a + t) % QM; v = (a - t + QM) % QM; end
      1: begin u = halve((a + b) % QM); v = halve((((a - b + QM) % QM) * w) % QM); end
      2: begin u = (a + t) % QM; v = t; end
      default: begin u = (a + b) % QM; v = (a - b + QM) % QM; end
    endcase
  endtask

  task automatic send(input int a, input int b, input int w, input int m,
                      input int eu, input int ev, input bit push, input bit chk);
    int   n;
    exp_t e;
    @(negedge clk);
    a_i = 12'(a); b_i = 12'(b); w_i = 12'(w); mode_i = 2'(m); valid_i = 1'b1;
    #1;
    n = 0;
    while (!ready_o && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!ready_o) begin
      check("accept_timeout", 0, 1);
      valid_i = 1'b0;
    end else begin
      e.u = 12'(eu); e.v = 12'(ev); e.acc = cyc; e.chk = chk;
      @(posedge clk);
      if (push) sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  // Monitor: pops on every output transfer, also watches stall behaviour.
  logic [11:0] hu, hv;
  bit          held = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall_hold_valid", int'(valid_o), 1);
        check("stall_hold_u", int'(u_o), int'(hu));
        check("stall_hold_v", int'(v_o), int'(hv));
      end
      if (valid_o && !ready_i) begin
        check("ready_o_stall", int'(ready_o), 0);
        held = 1'b1; hu = u_o; hv = v_o;
      end else begin
        held = 1'b0;
      end
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_u", int'(u_o), int'(e.u));
          check("out_v", int'(v_o), int'(e.v));
          if (e.chk) check("latency", cyc - e.acc, LAT);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int eu, ev;
    repeat (2) @(negedge clk);
    #2;
    check("rst_valid_o", int'(valid_o), 0);
    check("rst_u_o", int'(u_o), 0);
    check("rst_v_o", int'(v_o), 0);
    check("rst_ready_o", int'(ready_o), 1);
    @(negedge clk);
    rst = 1'b0;

    // Single CT beat, latency 3
    send(100, 2, 17, 0, 134, 66, 1, 1);
    idle();
    drain();

    // CT wrap-around cases
    send(3000, 1, 500, 0, 171, 2500, 1, 1);
    send(10, 1, 20, 0, 30, 3319, 1, 1);
    idle();
    drain();

    // GS
`ifdef PE_BFLY_HALVE_EN
    send(5, 3, 1, 1, 4, 1, 1, 1);
    send(3328, 2, 1, 1, 1665, 1663, 1, 1);
`else
    send(5, 3, 1, 1, 8, 2, 1, 1);
    send(3328, 2, 1, 1, 1, 3326, 1, 1);
`endif
    idle();
    drain();

    // Mixed modes back to back: fixed latency implies consecutive outputs
    send(100, 2, 17, 0, 134, 66, 1, 1);
`ifdef PE_BFLY_HALVE_EN
    send(5, 3, 1, 1, 4, 1, 1, 1);
`else
    send(5, 3, 1, 1, 8, 2, 1, 1);
`endif
    send(1, 2, 3, 2, 7, 6, 1, 1);
    send(0, 1, 5, 3, 1, 3328, 1, 1);
    idle();
    drain();

    // 20-beat stream with a 3-cycle sink stall
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          int a, b, w, m;
          a = (i * 523 + 17) % QM;
          b = (i * 1031 + 5) % QM;
          w = (i * 97 + 1) % QM;
          m = i % 4;
          ref_model(a, b, w, m, eu, ev);
          send(a, b, w, m, eu, ev, 1, 0);
        end
        idle();
      end
      begin
        repeat (8) @(negedge clk);
        ready_i = 1'b0;
        repeat (3) @(negedge clk);
        ready_i = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight: none may appear
    @(negedge clk);
    ready_i = 1'b0;
    send(11, 22, 33, 0, 0, 0, 0, 0);
    send(44, 55, 66, 1, 0, 0, 0, 0);
    send(77, 88, 99, 2, 0, 0, 0, 0);
    @(negedge clk);
    valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ready_i = 1'b1;
    #2;
    check("flush_valid_o", int'(valid_o), 0);
    check("flush_u_o", int'(u_o), 0);
    check("flush_v_o", int'(v_o), 0);
    check("flush_ready_o", int'(ready_o), 1);
    repeat (10) @(negedge clk);

    // Pipeline usable after the flush
    send(0, 1, 5, 3, 1, 3328, 1, 1);
    idle();
    drain();
    repeat (3) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_bfly.md
PE_BFLY -- requirements
Module: pe_bfly

Interface
REQ-001 SHALL have parameter COEFF_W, default 12, coefficient width.
REQ-002 SHALL have parameter Q, default 3329, modulus.
REQ-003 SHALL have parameter MUL_LAT, default 2 (range 1..4), internal modular-multiplier pipeline depth.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports a_i, b_i, w_i  input  COEFF_W each  operands and twiddle, each < Q.
REQ-007 SHALL have port mode_i  input  2  0=CT, 1=GS, 2=MAC, 3=ADDSUB.
REQ-008 SHALL have ports valid_i  input  1 and ready_o  output  1  input handshake.
REQ-009 SHALL have ports u_o, v_o  output  COEFF_W each  results, each < Q.
REQ-010 SHALL have ports valid_o  output  1 and ready_i  input  1  output handshake.

Function
REQ-011 SHALL accept a beat when valid_i && ready_o; mode_i is captured with the beat and travels with it, so modes may change every beat.
REQ-012 SHALL compute CT: t=b*w mod Q; u=(a+t) mod Q; v=(a-t) mod Q.
REQ-013 SHALL compute GS: u=(a+b) mod Q; v=((a-b) mod Q)*w mod Q; both halved per REQ-024.
REQ-014 SHALL compute MAC: t=b*w mod Q; u=(a+t) mod Q; v=t.
REQ-015 SHALL compute ADDSUB: u=(a+b) mod Q; v=(a-b) mod Q.
REQ-016 SHALL have fixed latency MUL_LAT+1 cycles from acceptance to valid_o for every mode; in-order, one beat per cycle when unstalled.
REQ-017 SHALL order stages as: CT/MAC multiply, then add/sub; GS add/sub, then multiply; operands not in use are carried in aligned delay registers.
REQ-018 SHALL treat a subtraction that goes below zero as adding Q; a sum >= Q SHALL have Q subtracted; no result ever equals or exceeds Q.
REQ-019 SHALL stall the whole pipeline (all stage registers hold) when valid_o && !ready_i; ready_o = !(valid_o && !ready_i).
REQ-020 SHALL allow pipeline bubbles to collapse; a bubble stage SHALL advance even while later stages hold.
REQ-021 SHALL hold u_o/v_o stable while valid_o && !ready_i.
REQ-022 SHALL leave out-of-range inputs (>= Q) with undefined results, but handshake and latency SHALL be unaffected.

Reset
REQ-023 SHALL, while rst is high at a clock edge, clear all stage valid bits, drive valid_o=0, u_o=0, v_o=0 and ready_o=1 from the next cycle; in-flight beats are discarded.

Configuration
REQ-024 With PE_BFLY_HALVE_EN defined, GS outputs SHALL be multiplied by 2^-1 mod Q (even x -> x/2, odd x -> (x+Q)/2) after the final stage, combinationally with no added latency; without it, GS outputs SHALL be unhalved and the halving logic absent.

Structure
REQ-025 SHALL take coeff_t, the mode enum and Q from the shared poly-arith package.
REQ-026 SHALL instantiate the existing modular adder, subtractor, multiplier and divide-by-2 leaves, plus one new sub-module pe_bfly_delay (parametrised-depth register line with per-stage enable) for alignment.

Verification (Q=3329, MUL_LAT=2)
REQ-027 CT a=100,b=2,w=17 -> u=134, v=66, valid_o exactly 3 cycles after acceptance.
REQ-028 CT wrap a=3000,b=1,w=500 -> u=171, v=2500; CT a=10,b=1,w=20 -> v=3319.
REQ-029 GS a=5,b=3,w=1 -> u=4, v=1 with macro, u=8, v=2 without; GS a=3328,b=2,w=1 -> u=1665 with macro.
REQ-030 Back-to-back stream CT,GS,MAC(a=1,b=2,w=3 -> u=7,v=6),ADDSUB(a=0,b=1 -> u=1,v=3328) -> four results in order on consecutive cycles.
REQ-031 20-beat stream with ready_i low for 3 cycles mid-stream -> no beat lost/duplicated, outputs stable while stalled, ready_o low during the stall.
REQ-032 rst asserted with 3 beats in flight -> valid_o=0, u_o=v_o=0 next cycle; none of those beats ever appears.
